// File: rtl/enum_symbol_tx.sv
// Serial transmitter for enum-typed symbols: one 2-bit symbol per valid/ready
// handshake, framed as START, two data bits (LSB first), optional even parity, STOP.

package p;
    typedef enum logic {FALSE = 1'b0, TRUE = 1'b1} bool_t;
endpackage

package q;
    typedef enum logic [1:0] {
        ORIGINAL = 2'd0,
        WHITENED = 2'd1,
        CHIPPED  = 2'd2,
        MISSING  = 2'd3
    } teeth_t;
endpackage

module enum_symbol_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_sym,
    output logic       in_ready,
    output logic       tx_line,
    output logic       busy,
    output logic [7:0] sent_count
);
    import p::*;
    import q::teeth_t;
    import q::ORIGINAL;

    // Bit-hold counter must still be one bit wide when each bit lasts one cycle.
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bit_idx_q;
    teeth_t           shift_q;
    logic             tx_q;
    bool_t            busy_q;
    logic [7:0]       sent_q;

    logic [1:0]       sym_bits;
    logic             bit_done;
    logic             accept;

    // Handshake and bit-timing decode.
    assign sym_bits   = shift_q;
    assign bit_done   = (cnt_q == LAST_CNT);
    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid && in_ready;
    assign tx_line    = tx_q;
    assign busy       = (busy_q == TRUE);
    assign sent_count = sent_q;

    // Frame sequencer: state, bit timing, registered line/busy and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 1'b0;
            shift_q   <= ORIGINAL;
            tx_q      <= 1'b1;
            busy_q    <= FALSE;
            sent_q    <= 8'd0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                shift_q   <= teeth_t'(in_sym);
                state_q   <= START;
                cnt_q     <= '0;
                bit_idx_q <= 1'b0;
                tx_q      <= 1'b0;
                busy_q    <= TRUE;
            end
        end else if (!bit_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
            case (state_q)
                START: begin
                    state_q   <= DATA;
                    bit_idx_q <= 1'b0;
                    tx_q      <= sym_bits[0];
                end
                DATA: begin
                    if (!bit_idx_q) begin
                        bit_idx_q <= 1'b1;
                        tx_q      <= sym_bits[1];
                    end else if (PARITY_EN != 0) begin
                        state_q <= PARITY;
                        tx_q    <= ^sym_bits;
                    end else begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
                STOP: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= FALSE;
                    sent_q  <= sent_q + 8'd1;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= FALSE;
                end
            endcase
        end
    end

endmodule
